// File: rtl/pc_fetch_if.sv
// Fetch-stage bundle between the control/decode side and the PC unit.
// Handshake: fetch_valid qualifies ins_addr; there is no ready, stall is the only back-pressure.
interface pc_fetch_if;
   logic        stall;
   logic        branch_taken;
   logic [15:0] branch_offset;
   logic        jump;
   logic [25:0] jump_index;
   logic        jump_reg;
   logic [31:0] jr_target;
   logic        halt_req;
   logic [31:0] ins_addr;
   logic [31:0] pc_plus4;
   logic        fetch_valid;
   logic [1:0]  state;
   logic        fault;
   logic [31:0] fault_pc;
   logic [31:0] retired_cnt;

   modport master (
      output stall, branch_taken, branch_offset, jump, jump_index,
             jump_reg, jr_target, halt_req,
      input  ins_addr, pc_plus4, fetch_valid, state, fault, fault_pc, retired_cnt
   );

   modport slave (
      input  stall, branch_taken, branch_offset, jump, jump_index,
             jump_reg, jr_target, halt_req,
      output ins_addr, pc_plus4, fetch_valid, state, fault, fault_pc, retired_cnt
   );
endinterface

// File: rtl/pc_fetch_unit.sv
// Program counter and next-PC selection for the single-cycle MIPS core,
// with fetch-window guarding, halt/fault states and a retired-fetch counter.
module pc_fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_3000,
   parameter logic [31:0] IMEM_BASE = 32'h0000_3000,
   parameter logic [31:0] IMEM_LAST = 32'h0000_3400
) (
   input  logic       clk,
   input  logic       reset,
   pc_fetch_if.slave  bus
);

   typedef enum logic [1:0] {
      ST_RUN   = 2'b00,
      ST_HALT  = 2'b01,
      ST_FAULT = 2'b10,
      ST_BAD   = 2'b11
   } state_t;

   state_t      st;
   logic [31:0] pc;
   logic [31:0] fault_pc_q;
   logic [31:0] cnt;
   logic        fault_q;

   logic [31:0] seq_tgt;
   logic [31:0] branch_tgt;
   logic [31:0] jump_tgt;
   logic [31:0] target;
   logic        legal;

   assign seq_tgt    = pc + 32'd4;
   assign branch_tgt = seq_tgt + {{14{bus.branch_offset[15]}}, bus.branch_offset, 2'b00};
   assign jump_tgt   = {seq_tgt[31:28], bus.jump_index, 2'b00};

   always_comb begin
      target = seq_tgt;
      if (bus.jump_reg)          target = bus.jr_target;
      else if (bus.jump)         target = jump_tgt;
      else if (bus.branch_taken) target = branch_tgt;
   end

   assign legal = (target[1:0] == 2'b00) && (target >= IMEM_BASE) && (target <= IMEM_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         st         <= ST_RUN;
         pc         <= RESET_PC;
         fault_pc_q <= 32'd0;
         cnt        <= 32'd0;
         fault_q    <= 1'b0;
      end else begin
         case (st)
            ST_RUN: begin
               // Halt outranks stall and every redirect; stall suppresses target checking.
               if (bus.halt_req) begin
                  st <= ST_HALT;
               end else if (!bus.stall) begin
                  if (legal) begin
                     pc  <= target;
                     cnt <= cnt + 32'd1;
                  end else begin
                     st         <= ST_FAULT;
                     fault_pc_q <= target;
                     fault_q    <= 1'b1;
                  end
               end
            end
            ST_BAD:  fault_q <= 1'b1;
            default: ;
         endcase
      end
   end

   assign bus.ins_addr    = pc;
   assign bus.pc_plus4    = seq_tgt;
   assign bus.fetch_valid = (st == ST_RUN);
   assign bus.state       = st;
   assign bus.fault       = fault_q;
   assign bus.fault_pc    = fault_pc_q;
   assign bus.retired_cnt = cnt;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed scenarios plus randomized traffic against a
// behavioural model of the fetch rules.
module tb_pc_fetch_unit;

   localparam logic [31:0] BASE = 32'h0000_3000;
   localparam logic [31:0] LAST = 32'h0000_3400;

   logic clk;
   logic reset;
   int   tests_run;
   int   tests_failed;

   pc_fetch_if bus ();

   pc_fetch_unit dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // behavioural model: 0 run, 1 halt, 2 fault
   logic [31:0] m_pc;
   logic [31:0] m_cnt;
   logic [31:0] m_fpc;
   logic [1:0]  m_st;

   task automatic model_reset();
      m_pc  = BASE;
      m_cnt = 0;
      m_fpc = 0;
      m_st  = 2'd0;
   endtask

   task automatic model_step(input logic s, bt, input logic [15:0] off, input logic j,
                             input logic [25:0] idx, input logic jr,
                             input logic [31:0] jrt, input logic h);
      logic [31:0] t;
      int so;
      if (m_st != 2'd0) return;
      if (h) begin
         m_st = 2'd1;
         return;
      end
      if (s) return;
      so = $signed(off);
      if (jr)      t = jrt;
      else if (j)  t = ((m_pc + 32'd4) & 32'hF000_0000) | (32'(idx) * 32'd4);
      else if (bt) t = m_pc + 32'd4 + 32'(so * 4);
      else         t = m_pc + 32'd4;
      if ((t % 4 == 0) && t >= BASE && t <= LAST) begin
         m_pc  = t;
         m_cnt = m_cnt + 1;
      end else begin
         m_st  = 2'd2;
         m_fpc = t;
      end
   endtask

   // drivers
   task automatic cycle(input logic s, bt, input logic [15:0] off, input logic j,
                        input logic [25:0] idx, input logic jr,
                        input logic [31:0] jrt, input logic h);
      bus.stall         = s;
      bus.branch_taken  = bt;
      bus.branch_offset = off;
      bus.jump          = j;
      bus.jump_index    = idx;
      bus.jump_reg      = jr;
      bus.jr_target     = jrt;
      bus.halt_req      = h;
      @(posedge clk);
      model_step(s, bt, off, j, idx, jr, jrt, h);
      #1;
   endtask

   task automatic idle();
      cycle(0, 0, 16'h0, 0, 26'h0, 0, 32'h0, 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      model_reset();
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   // scenarios
   task automatic test_reset();
      do_reset();
      tests_run++; if (bus.ins_addr !== 32'h3000) begin tests_failed++; $display("FAIL reset_pc got=%h exp=%h", bus.ins_addr, 32'h3000); end
      tests_run++; if (bus.state !== 2'b00) begin tests_failed++; $display("FAIL reset_state got=%b exp=00", bus.state); end
      tests_run++; if (bus.fault !== 1'b0 || bus.fault_pc !== 32'h0) begin tests_failed++; $display("FAIL reset_fault got=%b/%h exp=0/0", bus.fault, bus.fault_pc); end
      tests_run++; if (bus.retired_cnt !== 32'h0) begin tests_failed++; $display("FAIL reset_cnt got=%0d exp=0", bus.retired_cnt); end
      tests_run++; if (bus.pc_plus4 !== 32'h3004) begin tests_failed++; $display("FAIL reset_plus4 got=%h exp=3004", bus.pc_plus4); end
   endtask

   task automatic test_sequential();
      logic [31:0] exp_q[$];
      exp_q = '{32'h3004, 32'h3008, 32'h300C};
      foreach (exp_q[i]) begin
         idle();
         tests_run++; if (bus.ins_addr !== exp_q[i]) begin tests_failed++; $display("FAIL seq_pc[%0d] got=%h exp=%h", i, bus.ins_addr, exp_q[i]); end
         tests_run++; if (bus.fetch_valid !== 1'b1) begin tests_failed++; $display("FAIL seq_valid[%0d] got=%b exp=1", i, bus.fetch_valid); end
      end
      tests_run++; if (bus.retired_cnt !== 32'd3) begin tests_failed++; $display("FAIL seq_cnt got=%0d exp=3", bus.retired_cnt); end
   endtask

   task automatic test_branch_jump();
      idle();
      tests_run++; if (bus.ins_addr !== 32'h3010) begin tests_failed++; $display("FAIL pre_branch_pc got=%h exp=3010", bus.ins_addr); end
      cycle(0, 1, 16'hFFFC, 0, 26'h0, 0, 32'h0, 0);
      tests_run++; if (bus.ins_addr !== 32'h3004) begin tests_failed++; $display("FAIL branch_back got=%h exp=3004", bus.ins_addr); end
      cycle(0, 0, 16'h0, 1, 26'h0000C08, 0, 32'h0, 0);
      tests_run++; if (bus.ins_addr !== 32'h3020) begin tests_failed++; $display("FAIL jump_pc got=%h exp=3020", bus.ins_addr); end
      tests_run++; if (bus.retired_cnt !== 32'd6) begin tests_failed++; $display("FAIL bj_cnt got=%0d exp=6", bus.retired_cnt); end
   endtask

   task automatic test_priority();
      cycle(0, 1, 16'h0010, 1, 26'h0000C40, 1, 32'h3100, 0);
      tests_run++; if (bus.ins_addr !== 32'h3100) begin tests_failed++; $display("FAIL jr_priority got=%h exp=3100", bus.ins_addr); end
      cycle(0, 1, 16'h0010, 1, 26'h0000C40, 0, 32'h3200, 0);
      tests_run++; if (bus.ins_addr !== 32'h3100) begin tests_failed++; $display("FAIL jump_priority got=%h exp=3100", bus.ins_addr); end
   endtask

   task automatic test_stall_halt();
      do_reset();
      idle(); idle();
      for (int i = 0; i < 3; i++) begin
         cycle(1, 1, 16'h0004, 0, 26'h0, 0, 32'h0, 0);
         tests_run++; if (bus.ins_addr !== 32'h3008 || bus.retired_cnt !== 32'd2) begin tests_failed++; $display("FAIL stall[%0d] got=%h/%0d exp=3008/2", i, bus.ins_addr, bus.retired_cnt); end
      end
      cycle(1, 0, 16'h0, 0, 26'h0, 0, 32'h0, 1);
      tests_run++; if (bus.state !== 2'b01 || bus.fetch_valid !== 1'b0) begin tests_failed++; $display("FAIL halt_state got=%b/%b exp=01/0", bus.state, bus.fetch_valid); end
      for (int i = 0; i < 5; i++) begin
         cycle(0, 1, 16'h0002, i[0], 26'h0000C10, 1, 32'h3040, 0);
         tests_run++; if (bus.ins_addr !== 32'h3008 || bus.state !== 2'b01 || bus.retired_cnt !== 32'd2) begin tests_failed++; $display("FAIL halt_frozen[%0d] got=%h/%b/%0d exp=3008/01/2", i, bus.ins_addr, bus.state, bus.retired_cnt); end
      end
   endtask

   task automatic test_fault_jr();
      do_reset();
      cycle(0, 0, 16'h0, 0, 26'h0, 1, 32'h3002, 0);
      tests_run++; if (bus.state !== 2'b10 || bus.fault !== 1'b1) begin tests_failed++; $display("FAIL jr_fault_state got=%b/%b exp=10/1", bus.state, bus.fault); end
      tests_run++; if (bus.fault_pc !== 32'h3002 || bus.ins_addr !== 32'h3000) begin tests_failed++; $display("FAIL jr_fault_pc got=%h/%h exp=3002/3000", bus.fault_pc, bus.ins_addr); end
      cycle(0, 0, 16'h0, 0, 26'h0, 1, 32'h2FFC, 0);
      tests_run++; if (bus.fault_pc !== 32'h3002 || bus.state !== 2'b10) begin tests_failed++; $display("FAIL fault_frozen got=%h/%b exp=3002/10", bus.fault_pc, bus.state); end
      do_reset();
      cycle(0, 0, 16'h0, 0, 26'h0, 1, 32'h2FFC, 0);
      tests_run++; if (bus.fault_pc !== 32'h2FFC || bus.state !== 2'b10) begin tests_failed++; $display("FAIL below_base got=%h/%b exp=2ffc/10", bus.fault_pc, bus.state); end
   endtask

   task automatic test_fault_seq_end();
      do_reset();
      cycle(0, 0, 16'h0, 0, 26'h0, 1, 32'h3400, 0);
      tests_run++; if (bus.ins_addr !== 32'h3400 || bus.state !== 2'b00) begin tests_failed++; $display("FAIL last_legal got=%h/%b exp=3400/00", bus.ins_addr, bus.state); end
      idle();
      tests_run++; if (bus.fault_pc !== 32'h3404 || bus.state !== 2'b10 || bus.ins_addr !== 32'h3400) begin tests_failed++; $display("FAIL seq_overrun got=%h/%b/%h exp=3404/10/3400", bus.fault_pc, bus.state, bus.ins_addr); end
      tests_run++; if (bus.retired_cnt !== 32'd1) begin tests_failed++; $display("FAIL overrun_cnt got=%0d exp=1", bus.retired_cnt); end
   endtask

   task automatic test_async_reset();
      @(negedge clk);
      #2;
      reset = 1'b1;
      model_reset();
      #1;
      tests_run++; if (bus.ins_addr !== 32'h3000 || bus.state !== 2'b00 || bus.fault !== 1'b0) begin tests_failed++; $display("FAIL async_rst got=%h/%b/%b exp=3000/00/0", bus.ins_addr, bus.state, bus.fault); end
      tests_run++; if (bus.fault_pc !== 32'h0 || bus.retired_cnt !== 32'h0) begin tests_failed++; $display("FAIL async_rst_regs got=%h/%0d exp=0/0", bus.fault_pc, bus.retired_cnt); end
      #1;
      reset = 1'b0;
      idle();
      tests_run++; if (bus.ins_addr !== 32'h3004 || bus.fetch_valid !== 1'b1) begin tests_failed++; $display("FAIL resume got=%h/%b exp=3004/1", bus.ins_addr, bus.fetch_valid); end
   endtask

   task automatic test_random();
      int stuck;
      logic s, bt, j, jr, h;
      logic [15:0] off;
      logic [25:0] idx;
      logic [31:0] jrt;
      int so;
      stuck = 0;
      do_reset();
      for (int n = 0; n < 600; n++) begin
         s   = ($urandom_range(0, 7) == 0);
         h   = ($urandom_range(0, 150) == 0);
         bt  = ($urandom_range(0, 3) == 0);
         j   = ($urandom_range(0, 15) == 0);
         jr  = ($urandom_range(0, 15) == 0);
         so  = int'($urandom_range(0, 64)) - 32;
         off = ($urandom_range(0, 19) == 0) ? 16'($urandom) : 16'(so);
         idx = ($urandom_range(0, 9) == 0) ? 26'($urandom) : 26'(32'h0C00 + $urandom_range(0, 260));
         jrt = ($urandom_range(0, 9) == 0) ? $urandom : (32'h3000 + ($urandom_range(0, 258) << 2));
         cycle(s, bt, off, j, idx, jr, jrt, h);
         tests_run++;
         if (bus.ins_addr !== m_pc || bus.pc_plus4 !== m_pc + 32'd4 || bus.state !== m_st ||
             bus.fault !== (m_st == 2'd2) || bus.fault_pc !== m_fpc || bus.retired_cnt !== m_cnt ||
             bus.fetch_valid !== (m_st == 2'd0)) begin
            tests_failed++;
            $display("FAIL rand[%0d] got pc=%h st=%b f=%b fpc=%h cnt=%0d v=%b exp pc=%h st=%b fpc=%h cnt=%0d",
                     n, bus.ins_addr, bus.state, bus.fault, bus.fault_pc, bus.retired_cnt,
                     bus.fetch_valid, m_pc, m_st, m_fpc, m_cnt);
         end
         if (m_st != 2'd0) stuck++;
         if (stuck > 3) begin
            stuck = 0;
            do_reset();
         end
      end
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      reset        = 1'b0;
      bus.stall = 0; bus.branch_taken = 0; bus.branch_offset = 0; bus.jump = 0;
      bus.jump_index = 0; bus.jump_reg = 0; bus.jr_target = 0; bus.halt_req = 0;
      model_reset();
      test_reset();
      test_sequential();
      test_branch_jump();
      test_priority();
      test_stall_halt();
      test_fault_jr();
      test_fault_seq_end();
      test_async_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
